// File: rtl/fht_out_mix.sv
// -----------------------------------------------------------------------------
// fht_out_mix
//
// Write-back demultiplexer for the FHT butterfly datapath. Each accepted beat
// carries four butterfly results (sum, diff, cos-path, sin-path). Each result
// is halved and steered to one of four memory banks. The bank-swap rule is the
// same one the read side uses. The block also produces per-bank write enables,
// a shared write address and an end-of-stage pulse. One stage is
// 2^ADDR_BIT beats.
//
// Optional feature: define FHT_OUT_RND_EN to round half up, (x + 1) >>> 1,
// instead of truncating with x >>> 1. Latency is unchanged.
//
// Ports
//   iCLK            in   clock, rising edge
//   iRESET          in   asynchronous active-high reset
//   iSTART          in   pulse: begin a new stage and clear the address counter
//   iVALID          in   butterfly result beat valid (accepted only while busy)
//   iST_ZERO        in   first-stage (zero-angle) mode: only banks 0/1 written
//   iSECTOR         in   [SEC_BIT]    sector index of the current beat
//   iX_0..iX_3      in   [D_BIT+1]    signed butterfly results
//   oBANK_0..3      out  [D_BIT]      signed write data per bank (registered)
//   oWE             out  [4]          per-bank write enable, bit n -> bank n
//   oADDR           out  [ADDR_BIT]   write address shared by all banks
//   oBUSY           out  high while a stage is being written
//   oDONE           out  one-cycle pulse with the last write of a stage
// -----------------------------------------------------------------------------
module fht_out_mix #(
  parameter int D_BIT    = 17,
  parameter int SEC_BIT  = 9,
  parameter int ADDR_BIT = 8
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iSTART,
  input  logic                       iVALID,
  input  logic                       iST_ZERO,
  input  logic [SEC_BIT-1:0]         iSECTOR,
  input  logic signed [D_BIT:0]      iX_0,
  input  logic signed [D_BIT:0]      iX_1,
  input  logic signed [D_BIT:0]      iX_2,
  input  logic signed [D_BIT:0]      iX_3,
  output logic signed [D_BIT-1:0]    oBANK_0,
  output logic signed [D_BIT-1:0]    oBANK_1,
  output logic signed [D_BIT-1:0]    oBANK_2,
  output logic signed [D_BIT-1:0]    oBANK_3,
  output logic [3:0]                 oWE,
  output logic [ADDR_BIT-1:0]        oADDR,
  output logic                       oBUSY,
  output logic                       oDONE
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_BIT-1:0]     cnt_q;
  logic                    accept;
  logic                    last_beat;
  logic [3:0][D_BIT-1:0]   bank_d;
  logic [3:0]              we_d;
  logic [D_BIT-1:0]        y0, y1, y2, y3;

  // Halve one butterfly result. The sign extension to D_BIT+2 bits gives the
  // optional +1 headroom, so the most positive input cannot wrap before the
  // shift. The low D_BIT bits of the shifted value are the bank word.
  function automatic logic [D_BIT-1:0] scale(input logic signed [D_BIT:0] x);
    logic signed [D_BIT+1:0] ext;
    ext = {x[D_BIT], x};
`ifdef FHT_OUT_RND_EN
    ext = ext + {{(D_BIT+1){1'b0}}, 1'b1};
`else
`endif
    ext = ext >>> 1;
    return ext[D_BIT-1:0];
  endfunction

  // iSTART always wins: a beat on the same edge as a (re)start is dropped.
  assign accept    = (state_q == WRITE) && iVALID && !iSTART;
  assign last_beat = (cnt_q == {ADDR_BIT{1'b1}});

  assign y0 = scale(iX_0);
  assign y1 = scale(iX_1);
  assign y2 = scale(iX_2);
  assign y3 = scale(iX_3);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the simulator runs the blocks in.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  // NOTE: the default assignment before the case keeps this block free of
  // inferred latches on paths that do not change state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iSTART)                state_d = WRITE;
      WRITE:   if (accept && last_beat)   state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // FSM: output logic
  always_comb begin
    oBUSY = (state_q == WRITE);
  end

  // ---------------------------------------------------------------------------
  // Bank routing. Odd sectors swap the sum/diff pair between banks 0 and 1.
  // Sectors >= 2 also swap the cos/sin pair between banks 2 and 3. Sectors 0
  // and 1 carry no sin-path term, so bank 3 is not written. In zero-angle mode
  // only the sum/diff pair is written. Unwritten banks get data 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    bank_d = '0;
    we_d   = 4'b0000;
    if (iST_ZERO) begin
      bank_d[0] = y0;
      bank_d[1] = y1;
      we_d      = 4'b0011;
    end else if (iSECTOR == '0) begin
      bank_d[0] = y0;
      bank_d[1] = y1;
      bank_d[2] = y2;
      we_d      = 4'b0111;
    end else if (iSECTOR == SEC_BIT'(1)) begin
      bank_d[1] = y0;
      bank_d[0] = y1;
      bank_d[2] = y2;
      we_d      = 4'b0111;
    end else if (!iSECTOR[0]) begin
      bank_d[0] = y0;
      bank_d[1] = y1;
      bank_d[2] = y2;
      bank_d[3] = y3;
      we_d      = 4'b1111;
    end else begin
      bank_d[1] = y0;
      bank_d[0] = y1;
      bank_d[3] = y2;
      bank_d[2] = y3;
      we_d      = 4'b1111;
    end
  end

  // ---------------------------------------------------------------------------
  // Address counter: cleared by every start. It wraps naturally after the
  // last beat of a stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)      cnt_q <= '0;
    else if (iSTART) cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registered write port. Write enables and oDONE are single-cycle strobes.
  // Data and address hold between writes.
  // ---------------------------------------------------------------------------
  // NOTE: the data registers are reset as well. Outputs are defined as zero
  // after reset, and these are plain flops rather than a memory array.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oBANK_0 <= '0;
      oBANK_1 <= '0;
      oBANK_2 <= '0;
      oBANK_3 <= '0;
      oWE     <= 4'b0000;
      oADDR   <= '0;
      oDONE   <= 1'b0;
    end else begin
      oWE   <= 4'b0000;
      oDONE <= 1'b0;
      if (accept) begin
        oBANK_0 <= bank_d[0];
        oBANK_1 <= bank_d[1];
        oBANK_2 <= bank_d[2];
        oBANK_3 <= bank_d[3];
        oWE     <= we_d;
        oADDR   <= cnt_q;
        oDONE   <= last_beat;
      end
    end
  end

endmodule

// File: tb/tb_fht_out_mix.sv
// -----------------------------------------------------------------------------
// tb_fht_out_mix
//
// Directed bench for fht_out_mix with a short stage (ADDR_BIT = 3). A
// behavioural model computes the expected outputs from the routing table and
// plain integer halving, and it is compared every cycle. Hand-computed literal
// checks pin the model and cover the corner cases.
// -----------------------------------------------------------------------------
module tb_fht_out_mix;

  localparam int D_BIT    = 17;
  localparam int SEC_BIT  = 9;
  localparam int ADDR_BIT = 3;
  localparam int STAGE    = 1 << ADDR_BIT;

  logic                    iCLK   = 1'b0;
  logic                    iRESET = 1'b1;
  logic                    iSTART = 1'b0;
  logic                    iVALID = 1'b0;
  logic                    iST_ZERO = 1'b0;
  logic [SEC_BIT-1:0]      iSECTOR = '0;
  logic signed [D_BIT:0]   iX_0 = '0, iX_1 = '0, iX_2 = '0, iX_3 = '0;
  logic signed [D_BIT-1:0] oBANK_0, oBANK_1, oBANK_2, oBANK_3;
  logic [3:0]              oWE;
  logic [ADDR_BIT-1:0]     oADDR;
  logic                    oBUSY, oDONE;

  fht_out_mix #(.D_BIT(D_BIT), .SEC_BIT(SEC_BIT), .ADDR_BIT(ADDR_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iVALID(iVALID),
    .iST_ZERO(iST_ZERO), .iSECTOR(iSECTOR),
    .iX_0(iX_0), .iX_1(iX_1), .iX_2(iX_2), .iX_3(iX_3),
    .oBANK_0(oBANK_0), .oBANK_1(oBANK_1), .oBANK_2(oBANK_2), .oBANK_3(oBANK_3),
    .oWE(oWE), .oADDR(oADDR), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    check(name, 128'(act), 128'(exp));
  endtask

  task automatic chk_b(input string name, input logic signed [D_BIT-1:0] act, input int exp);
    logic signed [D_BIT-1:0] ev;
    ev = D_BIT'(exp);
    check(name, 128'(act), 128'(ev));
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  // floor(x/2), or floor((x+1)/2) when rounding is enabled.
  function automatic int half(input int x);
    int v;
    v = x;
`ifdef FHT_OUT_RND_EN
    v = v + 1;
`endif
    return (v >= 0) ? v / 2 : -((1 - v) / 2);
  endfunction

  int        m_cnt  = 0;
  bit        m_busy = 1'b0;
  int        e_bank [4] = '{0, 0, 0, 0};
  logic [3:0] e_we   = 4'b0;
  int        e_addr = 0;
  bit        e_done = 1'b0;

  always @(posedge iCLK or posedge iRESET) begin
    int y [4];
    if (iRESET) begin
      m_cnt = 0; m_busy = 0; e_we = 0; e_addr = 0; e_done = 0;
      for (int n = 0; n < 4; n++) e_bank[n] = 0;
    end else begin
      e_we   = 4'b0;
      e_done = 1'b0;
      if (iSTART) begin
        m_busy = 1;
        m_cnt  = 0;
      end else if (m_busy && iVALID) begin
        y[0] = half(int'(iX_0)); y[1] = half(int'(iX_1));
        y[2] = half(int'(iX_2)); y[3] = half(int'(iX_3));
        for (int n = 0; n < 4; n++) e_bank[n] = 0;
        if (iST_ZERO) begin
          e_bank[0] = y[0]; e_bank[1] = y[1]; e_we = 4'b0011;
        end else if (iSECTOR == 0) begin
          e_bank[0] = y[0]; e_bank[1] = y[1]; e_bank[2] = y[2]; e_we = 4'b0111;
        end else if (iSECTOR == 1) begin
          e_bank[1] = y[0]; e_bank[0] = y[1]; e_bank[2] = y[2]; e_we = 4'b0111;
        end else if (iSECTOR % 2 == 0) begin
          for (int n = 0; n < 4; n++) e_bank[n] = y[n];
          e_we = 4'b1111;
        end else begin
          e_bank[1] = y[0]; e_bank[0] = y[1]; e_bank[3] = y[2]; e_bank[2] = y[3];
          e_we = 4'b1111;
        end
        e_addr = m_cnt;
        e_done = (m_cnt == STAGE - 1);
        if (e_done) m_busy = 0;
        m_cnt = (m_cnt + 1) % STAGE;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge iCLK) begin
    if (!iRESET) begin
      chk_b("cyc_bank0", oBANK_0, e_bank[0]);
      chk_b("cyc_bank1", oBANK_1, e_bank[1]);
      chk_b("cyc_bank2", oBANK_2, e_bank[2]);
      chk_b("cyc_bank3", oBANK_3, e_bank[3]);
      chk_i("cyc_ctl", {oWE, oBUSY, oDONE}, {e_we, m_busy, e_done});
      chk_i("cyc_addr", oADDR, e_addr);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Drive one cycle of inputs. On return, the outputs for that edge are settled.
  task automatic cyc(input bit st, input bit v, input bit z, input int sec,
                     input int x0, input int x1, input int x2, input int x3);
    iSTART = st; iVALID = v; iST_ZERO = z; iSECTOR = SEC_BIT'(sec);
    iX_0 = (D_BIT+1)'(x0); iX_1 = (D_BIT+1)'(x1);
    iX_2 = (D_BIT+1)'(x2); iX_3 = (D_BIT+1)'(x3);
    @(posedge iCLK); #1;
  endtask

  task automatic start();        cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();         cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic beat2();        cyc(0, 1, 0, 2, 10, 20, 30, 40); endtask

  initial begin
    repeat (2) @(posedge iCLK);
    #1;
    chk_i("rst_we", oWE, 0);
    chk_i("rst_busy_done", {oBUSY, oDONE}, 0);
    chk_i("rst_addr", oADDR, 0);
    iRESET = 1'b0;
    idle();

    // Reset mid-stage after 5 beats.
    start();
    repeat (5) beat2();
    chk_i("pre_rst_addr", oADDR, 4);
    iRESET = 1'b1;
    #1;
    chk_i("midrst_we", oWE, 0);
    chk_i("midrst_busy", oBUSY, 0);
    chk_i("midrst_addr", oADDR, 0);
    chk_b("midrst_bank0", oBANK_0, 0);
    chk_b("midrst_bank3", oBANK_3, 0);
    iSTART = 0; iVALID = 0;
    @(posedge iCLK); #1;
    iRESET = 1'b0;
    start();
    beat2();
    chk_i("post_rst_addr", oADDR, 0);

    // Even-sector stage (restart while busy, then a full stage).
    start();
    for (int i = 0; i < STAGE; i++) begin
      beat2();
      chk_b("even_b0", oBANK_0, 5);
      chk_b("even_b1", oBANK_1, 10);
      chk_b("even_b2", oBANK_2, 15);
      chk_b("even_b3", oBANK_3, 20);
      chk_i("even_we", oWE, 4'b1111);
      chk_i("even_addr", oADDR, i);
      chk_i("even_done", oDONE, (i == STAGE - 1));
      chk_i("even_busy", oBUSY, (i != STAGE - 1));
    end
    idle();
    chk_i("even_after_we", oWE, 0);
    chk_i("even_after_done", oDONE, 0);
    chk_b("even_hold_b0", oBANK_0, 5);

    // Odd sector 3.
    start();
    cyc(0, 1, 0, 3, -6, 8, -2, 4);
    chk_b("odd_b0", oBANK_0, 4);
    chk_b("odd_b1", oBANK_1, -3);
    chk_b("odd_b2", oBANK_2, 2);
    chk_b("odd_b3", oBANK_3, -1);
    chk_i("odd_we", oWE, 4'b1111);

    // Sector 1.
    cyc(0, 1, 0, 1, 10, 20, 30, 40);
    chk_i("sec1_we", oWE, 4'b0111);
    chk_b("sec1_b0", oBANK_0, 10);
    chk_b("sec1_b1", oBANK_1, 5);
    chk_b("sec1_b3", oBANK_3, 0);
    chk_i("sec1_addr", oADDR, 1);

    // Zero-angle mode ignores the sector.
    cyc(0, 1, 1, 5, 10, 20, 30, 40);
    chk_i("stz_we", oWE, 4'b0011);
    chk_b("stz_b0", oBANK_0, 5);
    chk_b("stz_b1", oBANK_1, 10);
    chk_b("stz_b2", oBANK_2, 0);

    // Rounding corners.
    cyc(0, 1, 0, 2, -3, 0, 0, 0);
`ifdef FHT_OUT_RND_EN
    chk_b("rnd_neg3", oBANK_0, -1);
`else
    chk_b("rnd_neg3", oBANK_0, -2);
`endif
    cyc(0, 1, 0, 2, (1 << D_BIT) - 1, 0, 0, 0);
`ifdef FHT_OUT_RND_EN
    chk_b("rnd_max", oBANK_0, 1 << (D_BIT - 1));
`else
    chk_b("rnd_max", oBANK_0, (1 << (D_BIT - 1)) - 1);
`endif
    chk_i("rnd_addr", oADDR, 4);

    // Restart with a beat on the same edge: the beat is dropped.
    beat2();
    chk_i("pre_restart_addr", oADDR, 5);
    cyc(1, 1, 0, 2, 10, 20, 30, 40);
    chk_i("restart_we", oWE, 0);
    chk_i("restart_done", oDONE, 0);
    beat2();
    chk_i("restart_addr", oADDR, 0);

    // Gap in iVALID: no write, address continues.
    beat2();
    chk_i("gap_a1", oADDR, 1);
    idle();
    chk_i("gap_we", oWE, 0);
    chk_i("gap_busy", oBUSY, 1);
    beat2();
    chk_i("gap_a2", oADDR, 2);
    for (int i = 3; i < STAGE; i++) beat2();
    chk_i("gap_done", oDONE, 1);
    chk_i("gap_last_addr", oADDR, STAGE - 1);

    // iVALID while idle is ignored.
    beat2();
    chk_i("idle_valid_we", oWE, 0);
    chk_i("idle_valid_busy", oBUSY, 0);

    // Start and valid together while idle: start only.
    cyc(1, 1, 0, 2, 10, 20, 30, 40);
    chk_i("idle_sv_we", oWE, 0);
    chk_i("idle_sv_busy", oBUSY, 1);
    beat2();
    chk_i("idle_sv_addr", oADDR, 0);
    chk_i("idle_sv_we2", oWE, 4'b1111);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
